cv32e40p_mult_tmr_ctrl: RTL and testbench

//  Fault-handling sequencer between the EX stage and the triplicated multiplier.

---
 rtl/cv32e40p_pkg.sv | 21 ++
 rtl/cv32e40p_sat_counter.sv | 34 +++
 rtl/cv32e40p_mult_tmr_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cv32e40p_mult_tmr_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_pkg
// Shared types and constants for the TMR multiplier fault-handling sequencer.
//   tmr_ctrl_state_e : sequencer states (idle, multiply in flight, retry gap)
//   TMR_MM_*         : bit positions inside the voter mismatch vector
// -----------------------------------------------------------------------------
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE  = 2'd0,
        TMR_BUSY  = 2'd1,
        TMR_RETRY = 2'd2
    } tmr_ctrl_state_e;

    // Mismatch vector layout: {ready, mulh_active, multicycle, result}
    localparam int TMR_MM_RESULT = 0;
    localparam int TMR_MM_MC     = 1;
    localparam int TMR_MM_MULH   = 2;
    localparam int TMR_MM_READY  = 3;

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// -----------------------------------------------------------------------------
// cv32e40p_sat_counter
// Saturating event counter with synchronous clear.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clr_i  : synchronous clear, wins over a same-cycle increment
//   inc_i  : count one event
//   cnt_o  : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module cv32e40p_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr_i) begin
            cnt_reg <= '0;
        end else if (inc_i && !(&cnt_reg)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/cv32e40p_mult_tmr_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e40p_mult_tmr_ctrl
// Sequencer between the EX stage and a triplicated multiplier. It gates the
// multiplier enable, samples the voter mismatch flags on every completion,
// re-executes a disagreeing multiply up to MAX_RETRY times and then forwards
// the voted result while raising a sticky alarm and a one-cycle interrupt.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable_i       : EX requests a multiply (held while stalled)
//   mult_ready_i   : voted ready from the TMR multiplier
//   mismatch_i     : voter disagreement {ready, mulh_active, multicycle, result}
//   clear_i        : clears alarm and all counters
//   stat_sel_i     : selects the per-output counter shown on stat_cnt_o
//   mult_enable_o  : enable to the TMR multiplier
//   ready_o        : multiply complete and accepted (to EX)
//   retry_o        : re-execution pending or in flight
//   alarm_o        : sticky, retries exhausted at least once
//   fault_irq_o    : one-cycle pulse on escalation
//   fault_cnt_o    : saturating count of all mismatch events
//   stat_cnt_o     : selected per-output mismatch count
//
// Build option: define CV32E40P_TMR_STATS_EN to get the four per-output
// mismatch counters; otherwise stat_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module cv32e40p_mult_tmr_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             mult_ready_i,
    input  logic [3:0]       mismatch_i,
    input  logic             clear_i,
    input  logic [1:0]       stat_sel_i,
    output logic             mult_enable_o,
    output logic             ready_o,
    output logic             retry_o,
    output logic             alarm_o,
    output logic             fault_irq_o,
    output logic [CNT_W-1:0] fault_cnt_o,
    output logic [CNT_W-1:0] stat_cnt_o
);

    localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RC_W-1:0] MAX_RC = RC_W'(MAX_RETRY);

    tmr_ctrl_state_e state_reg;
    logic [RC_W-1:0] retry_cnt_reg;
    logic            alarm_reg;

    logic completion;
    logic mismatch_ev;
    logic retries_left;
    logic escalate;

    // The enable follows EX directly in IDLE so an unprotected single-cycle
    // multiply sees no added latency; the RETRY gap forces it low so the
    // replica FSMs return to idle before the re-issue.
    always_comb begin
        mult_enable_o = 1'b0;
        case (state_reg)
            TMR_IDLE:  mult_enable_o = enable_i;
            TMR_BUSY:  mult_enable_o = 1'b1;
            default:   mult_enable_o = 1'b0;
        endcase
    end

    assign completion   = mult_enable_o & mult_ready_i;
    assign mismatch_ev  = completion & (|mismatch_i);
    assign retries_left = (retry_cnt_reg < MAX_RC);
    assign escalate     = mismatch_ev & ~retries_left;

    // Escalation still hands the voted result to EX: the core keeps running
    // and software decides what to do with the alarm.
    assign ready_o     = (completion & ~mismatch_ev) | escalate;
    assign fault_irq_o = escalate & ~clear_i;
    // A nonzero retry count means a re-issued multiply is in flight; the count
    // only returns to zero on the accepting ready_o.
    assign retry_o     = (state_reg == TMR_RETRY) | (retry_cnt_reg != '0);
    assign alarm_o     = alarm_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= TMR_IDLE;
            retry_cnt_reg <= '0;
        end else begin
            case (state_reg)
                TMR_IDLE, TMR_BUSY: begin
                    if (completion) begin
                        if (mismatch_ev && retries_left) begin
                            state_reg <= TMR_RETRY;
                        end else begin
                            state_reg     <= TMR_IDLE;
                            retry_cnt_reg <= '0;
                        end
                    end else if (state_reg == TMR_IDLE && enable_i) begin
                        state_reg <= TMR_BUSY;
                    end
                end
                TMR_RETRY: begin
                    retry_cnt_reg <= retry_cnt_reg + 1'b1;
                    state_reg     <= TMR_BUSY;
                end
                default: begin
                    state_reg     <= TMR_IDLE;
                    retry_cnt_reg <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_reg <= 1'b0;
        end else if (clear_i) begin
            alarm_reg <= 1'b0;
        end else if (escalate) begin
            alarm_reg <= 1'b1;
        end
    end

    cv32e40p_sat_counter #(
        .CNT_W (CNT_W)
    ) u_fault_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clear_i),
        .inc_i (mismatch_ev),
        .cnt_o (fault_cnt_o)
    );

`ifdef CV32E40P_TMR_STATS_EN
    logic [CNT_W-1:0] stat_cnt [TMR_MM_READY+1];

    generate
        for (genvar gi = 0; gi <= TMR_MM_READY; gi++) begin : g_stat
            cv32e40p_sat_counter #(
                .CNT_W (CNT_W)
            ) u_stat_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr_i (clear_i),
                .inc_i (mismatch_ev & mismatch_i[gi]),
                .cnt_o (stat_cnt[gi])
            );
        end
    endgenerate

    assign stat_cnt_o = stat_cnt[stat_sel_i];
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel_i;
    assign stat_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_mult_tmr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_mult_tmr_ctrl
// Directed and randomized multiply operations against a per-operation model:
// each op is a plan of up to MAX_RETRY+1 attempts (latency, mismatch flags,
// clear on completion); the model predicts ready/retry/irq cycle by cycle and
// keeps the expected counters and alarm as plain integers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cv32e40p_mult_tmr_ctrl;

    localparam int MAX_RETRY = 2;
    localparam int CNT_W     = 4;
    localparam int SAT       = (1 << CNT_W) - 1;
`ifdef CV32E40P_TMR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable_i;
    logic             mult_ready_i;
    logic [3:0]       mismatch_i;
    logic             clear_i;
    logic [1:0]       stat_sel_i;
    logic             mult_enable_o;
    logic             ready_o;
    logic             retry_o;
    logic             alarm_o;
    logic             fault_irq_o;
    logic [CNT_W-1:0] fault_cnt_o;
    logic [CNT_W-1:0] stat_cnt_o;

    cv32e40p_mult_tmr_ctrl #(
        .MAX_RETRY (MAX_RETRY),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable_i),
        .mult_ready_i  (mult_ready_i),
        .mismatch_i    (mismatch_i),
        .clear_i       (clear_i),
        .stat_sel_i    (stat_sel_i),
        .mult_enable_o (mult_enable_o),
        .ready_o       (ready_o),
        .retry_o       (retry_o),
        .alarm_o       (alarm_o),
        .fault_irq_o   (fault_irq_o),
        .fault_cnt_o   (fault_cnt_o),
        .stat_cnt_o    (stat_cnt_o)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state
    int exp_fault;
    int exp_stat [4];
    bit exp_alarm;

    // Current operation plan
    int         op_w   [3];
    logic [3:0] op_mm  [3];
    bit         op_clr [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        exp_fault = 0;
        exp_alarm = 1'b0;
        for (int k = 0; k < 4; k++) exp_stat[k] = 0;
    endtask

    task automatic plan(input int w0, input int w1, input int w2,
                        input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] m2,
                        input bit c0, input bit c1, input bit c2);
        op_w[0] = w0;   op_w[1] = w1;   op_w[2] = w2;
        op_mm[0] = m0;  op_mm[1] = m1;  op_mm[2] = m2;
        op_clr[0] = c0; op_clr[1] = c1; op_clr[2] = c2;
    endtask

    // Idle cycle: EX not requesting; check accumulated statistics.
    task automatic idle_check(input string tag);
        enable_i     = 1'b0;
        mult_ready_i = 1'($urandom);
        mismatch_i   = 4'($urandom);
        clear_i      = 1'b0;
        @(negedge clk);
        chk({tag, ".idle_en"},    32'(mult_enable_o), 32'd0);
        chk({tag, ".idle_rdy"},   32'(ready_o),       32'd0);
        chk({tag, ".idle_retry"}, 32'(retry_o),       32'd0);
        chk({tag, ".idle_irq"},   32'(fault_irq_o),   32'd0);
        chk({tag, ".fault_cnt"},  32'(fault_cnt_o),   32'(exp_fault));
        chk({tag, ".alarm"},      32'(alarm_o),       32'(exp_alarm));
        for (int s = 0; s < 4; s++) begin
            stat_sel_i = 2'(s);
            #1;
            chk($sformatf("%s.stat%0d", tag, s), 32'(stat_cnt_o),
                STATS ? 32'(exp_stat[s]) : 32'd0);
        end
        @(posedge clk); #1;
    endtask

    // Runs one multiply following op_* and checks every cycle of it.
    task automatic run_op(input string tag);
        bit done = 1'b0;
        for (int a = 0; a <= MAX_RETRY && !done; a++) begin
            for (int c = 0; c <= op_w[a]; c++) begin
                bit last = (c == op_w[a]);
                bit mm   = (op_mm[a] != 4'd0);
                bit clr  = last && op_clr[a];
                bit rdy  = last && (!mm || a == MAX_RETRY);
                bit esc  = last && mm && a == MAX_RETRY;
                enable_i     = 1'b1;
                mult_ready_i = last;
                mismatch_i   = last ? op_mm[a] : 4'($urandom);
                clear_i      = clr;
                stat_sel_i   = 2'($urandom);
                @(negedge clk);
                chk($sformatf("%s.a%0d.c%0d.en", tag, a, c),    32'(mult_enable_o), 32'd1);
                chk($sformatf("%s.a%0d.c%0d.rdy", tag, a, c),   32'(ready_o),       32'(rdy));
                chk($sformatf("%s.a%0d.c%0d.irq", tag, a, c),   32'(fault_irq_o),   32'(esc && !clr));
                chk($sformatf("%s.a%0d.c%0d.retry", tag, a, c), 32'(retry_o),       32'(a > 0));
                @(posedge clk); #1;
                if (last) begin
                    if (clr) begin
                        model_reset();
                    end else if (mm) begin
                        exp_fault = (exp_fault < SAT) ? exp_fault + 1 : SAT;
                        for (int k = 0; k < 4; k++)
                            if (op_mm[a][k]) exp_stat[k] = (exp_stat[k] < SAT) ? exp_stat[k] + 1 : SAT;
                        if (esc) exp_alarm = 1'b1;
                    end
                    done = rdy;
                end
            end
            if (!done) begin
                // Retry gap: the multiplier enable must drop for exactly one cycle.
                enable_i     = 1'b1;
                mult_ready_i = 1'($urandom);
                mismatch_i   = 4'($urandom);
                clear_i      = 1'b0;
                @(negedge clk);
                chk($sformatf("%s.gap%0d.en", tag, a),    32'(mult_enable_o), 32'd0);
                chk($sformatf("%s.gap%0d.rdy", tag, a),   32'(ready_o),       32'd0);
                chk($sformatf("%s.gap%0d.retry", tag, a), 32'(retry_o),       32'd1);
                chk($sformatf("%s.gap%0d.irq", tag, a),   32'(fault_irq_o),   32'd0);
                @(posedge clk); #1;
            end
        end
        idle_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        enable_i     = 1'b0;
        mult_ready_i = 1'b0;
        mismatch_i   = 4'd0;
        clear_i      = 1'b0;
        stat_sel_i   = 2'd0;
        model_reset();
        #12;
        chk("reset.en",    32'(mult_enable_o), 32'd0);
        chk("reset.rdy",   32'(ready_o),       32'd0);
        chk("reset.retry", 32'(retry_o),       32'd0);
        chk("reset.alarm", 32'(alarm_o),       32'd0);
        chk("reset.irq",   32'(fault_irq_o),   32'd0);
        chk("reset.fcnt",  32'(fault_cnt_o),   32'd0);
        chk("reset.scnt",  32'(stat_cnt_o),    32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle MUL, clean
        plan(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0); run_op("mul_clean");
        // MULH, mismatch on first completion only
        plan(2, 2, 2, 4'b0001, 4'd0, 4'd0, 0, 0, 0); run_op("mulh_retry1");
        // Mismatch on every completion -> escalation
        plan(1, 0, 2, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0); run_op("escalate");
        // Clear on the same cycle as a mismatch (event dropped, retry continues)
        plan(0, 1, 0, 4'b0100, 4'd0, 4'd0, 1, 0, 0); run_op("clear_mid");
        // Escalation with a same-cycle clear: no alarm, no irq
        plan(0, 0, 0, 4'b0001, 4'b0010, 4'b1000, 0, 0, 1); run_op("clear_esc");
        // Per-output statistics
        plan(0, 0, 0, 4'b1010, 4'd0, 4'd0, 0, 0, 0); run_op("stats_1010");

        // Reset while in the retry gap
        enable_i = 1'b1; mult_ready_i = 1'b1; mismatch_i = 4'b0001; clear_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_retry.before", 32'(retry_o), 32'd1);
        #2;
        rst_n = 1'b0; enable_i = 1'b0;
        #1;
        model_reset();
        chk("rst_retry.en",    32'(mult_enable_o), 32'd0);
        chk("rst_retry.retry", 32'(retry_o),       32'd0);
        chk("rst_retry.rdy",   32'(ready_o),       32'd0);
        chk("rst_retry.alarm", 32'(alarm_o),       32'd0);
        chk("rst_retry.fcnt",  32'(fault_cnt_o),   32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        plan(1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0); run_op("after_rst");

        // Drive the fault counter into saturation
        for (int i = 0; i < 6; i++) begin
            plan(0, 1, 0, 4'b1111, 4'b0011, 4'b1001, 0, 0, 0);
            run_op($sformatf("sat%0d", i));
        end

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            plan($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)),
                 $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)),
                 $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0);
            run_op($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
